// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, one-entry
// response buffer feeding the F/D register, redirect with late-response drop.
//
// state | meaning
// REQ   | no request outstanding, buffer empty; request fetch_pc
// WAIT  | one request granted, waiting for imem_rvalid
// FULL  | buffer holds a fetched instruction presented on instr_f
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halted,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_FULL = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        drop;
    logic        consume;
    logic        fire;
    logic [31:0] redirect_tgt;

    assign fetch_valid  = (state == S_FULL);
    assign consume      = fetch_valid & ~stall & ~halted;
    // Gated by reset so no request is visible while the block is held in reset.
    assign imem_req     = reset & ((state == S_REQ) | ((state == S_FULL) & consume))
                          & ~redirect & ~halted;
    assign imem_addr    = fetch_pc;
    assign fire         = imem_req & imem_gnt;
    assign redirect_tgt = redirect_pc & ~32'h0000_0003;

    assign instr_f = fetch_valid ? buf_instr : NOP;
    assign pc_f    = fetch_valid ? buf_pc : fetch_pc;
    assign pc4_f   = pc_f + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            buf_instr <= NOP;
            buf_pc    <= RESET_PC;
            drop      <= 1'b0;
        end else if (halted) begin
            // A granted request must still be retired so its response is never lost.
            if (state == S_WAIT && imem_rvalid) begin
                if (drop) begin
                    drop  <= 1'b0;
                    state <= S_REQ;
                end else begin
                    buf_instr <= imem_rdata;
                    buf_pc    <= req_pc;
                    state     <= S_FULL;
                end
            end
        end else if (redirect) begin
            fetch_pc <= redirect_tgt;
            case (state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        req_pc   <= fetch_pc;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= req_pc;
                            state     <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        if (fire) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            req_pc   <= fetch_pc;
                            state    <= S_WAIT;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP, default 32'h0000_0013 (addi x0,x0,0): bubble instruction.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-005 halted  in  1  core halted; freezes fetch.
REQ-006 stall  in  1  downstream hold; F/D register not capturing this cycle.
REQ-007 redirect  in  1  taken branch/jump from execute.
REQ-008 redirect_pc  in  32  redirect target.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  request address.
REQ-011 imem_gnt  in  1  memory accepts request this cycle.
REQ-012 imem_rvalid  in  1  read data valid.
REQ-013 imem_rdata  in  32  read data.
REQ-014 instr_f  out  32  instruction to F/D register.
REQ-015 pc_f  out  32  address of instr_f.
REQ-016 pc4_f  out  32  pc_f + 4.
REQ-017 fetch_valid  out  1  instr_f is a real fetched instruction.

Function
REQ-018 Shall hold fetch_pc (next address to request), FSM {REQ, WAIT, FULL}, drop flag, one-entry buffer (buf_instr, buf_pc).
REQ-019 At most one memory request outstanding at any time.
REQ-020 consume = fetch_valid & ~stall & ~halted.
REQ-021 imem_req = ((state==REQ) | (state==FULL & consume)) & ~redirect & ~halted; imem_addr = fetch_pc.
REQ-022 imem_req & imem_gnt: fetch_pc <= fetch_pc + 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), req_pc <= fetch_pc, state <= WAIT.
REQ-023 REQ without grant: stay REQ, imem_addr stable.
REQ-024 WAIT, imem_rvalid, drop=0: buf_instr <= imem_rdata, buf_pc <= req_pc, state <= FULL.
REQ-025 WAIT, imem_rvalid, drop=1: discard data, drop <= 0, state <= REQ.
REQ-026 FULL: fetch_valid=1, instr_f=buf_instr, pc_f=buf_pc; consume without grant -> REQ; consume with grant -> WAIT (back-to-back).
REQ-027 FULL & ~consume: hold buffer, no request.
REQ-028 Not FULL: fetch_valid=0, instr_f=NOP, pc_f=fetch_pc.
REQ-029 pc4_f = pc_f + 4, 32-bit wrap.
REQ-030 redirect & ~halted: fetch_pc <= {redirect_pc[31:2],2'b00}; REQ/FULL -> REQ (buffer invalidated); WAIT w/o rvalid -> stay WAIT, drop <= 1; WAIT with rvalid same cycle -> discard, REQ.
REQ-031 redirect has priority over consume and over buffer load.
REQ-032 halted=1: fetch_pc, buffer, state frozen, redirect ignored, no request; exception: WAIT & imem_rvalid still handled per REQ-024/025 (response never lost).
REQ-033 imem_rvalid outside WAIT shall be ignored.

Reset
REQ-034 reset=0 asynchronously: state=REQ, fetch_pc=RESET_PC, drop=0, buf_instr=NOP, buf_pc=RESET_PC, imem_req=0, fetch_valid=0, instr_f=NOP, pc_f=RESET_PC, pc4_f=RESET_PC+4.
REQ-035 Reset mid-transaction: any late response arrives in REQ and is ignored per REQ-033.
REQ-036 First request issued in first cycle after reset deasserts (unless halted/redirect).

Verification
REQ-037 Reset release, gnt=1, rvalid one cycle after each grant, rdata=0x00500093, stall=0 -> imem_addr 0x0,0x4,0x8...; fetch_valid on 0x0 two cycles after grant, pc4_f=0x4.
REQ-038 FULL with stall=1 for 3 cycles -> instr_f/pc_f held, imem_req=0; stall drop -> consume + new request same cycle.
REQ-039 WAIT, redirect=1, redirect_pc=0x0000_0103 -> drop set; next rvalid data discarded, fetch_valid=0; next imem_addr=0x0000_0100.
REQ-040 halted=1 in WAIT, rvalid with 0xDEADBEEF -> FULL, buf_instr=0xDEADBEEF, no request while halted, redirect ignored.
REQ-041 RESET_PC=0xFFFF_FFFC, gnt=1 -> next imem_addr=0x0000_0000; pc4_f for 0xFFFF_FFFC =0x0000_0000.
REQ-042 reset asserted in WAIT, stale rvalid after release -> ignored, fetch_valid=0, imem_addr=RESET_PC.
